// File: rtl/sbus_frame_ctrl.sv
// sbus_frame_ctrl: SBUS frame receiver (gap sync, 25-byte buffer writes, signal watchdog); define SBUS_ERR_CNT_EN to enable the aborted-frame counter
module sbus_frame_ctrl #(
    parameter int         GAP_CYCLES  = 50000,
    parameter int         WDOG_CYCLES = 1000000,
    parameter logic [7:0] HDR_BYTE    = 8'h0F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx_valid,
    input  logic        uart_rx_fe,
    input  logic        uart_rx_pe,
    input  logic [7:0]  uart_rx_data,
    output logic        byte_we,
    output logic [4:0]  byte_idx,
    output logic [7:0]  byte_data,
    output logic        frame_done,
    output logic        frame_err,
    output logic        frame_lost,
    output logic        failsafe,
    output logic        signal_ok,
    output logic [15:0] err_cnt
);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    typedef enum logic [1:0] {HUNT, WAIT_HDR, RECV} state_t;
    state_t state, state_n;
    logic [GW-1:0] gap_cnt;
    logic [WW-1:0] wdog_cnt;
    logic [4:0] idx, idx_n;
    logic [7:0] flags;
    logic gap, clean, last, wr, done, err;
    assign gap   = gap_cnt == GW'(GAP_CYCLES);
    assign clean = !uart_rx_fe && !uart_rx_pe;
    assign last  = idx == 5'd24;
    // next state and this cycle's write/accept/abort decision; a received byte always takes priority over the gap
    always_comb begin
        state_n = state;
        idx_n   = 5'd0;
        wr      = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        case (state)
            HUNT: state_n = (!uart_rx_valid && gap) ? WAIT_HDR : HUNT;
            WAIT_HDR: begin
                if (uart_rx_valid && clean && uart_rx_data == HDR_BYTE) begin
                    wr      = 1'b1;
                    idx_n   = 5'd1;
                    state_n = RECV;
                end else if (uart_rx_valid) begin
                    err     = 1'b1;
                    state_n = HUNT;
                end
            end
            RECV: begin
                if (uart_rx_valid && (!clean || (last && uart_rx_data != 8'h00))) begin
                    err     = 1'b1;
                    state_n = HUNT;
                end else if (uart_rx_valid) begin
                    wr      = 1'b1;
                    done    = last;
                    idx_n   = last ? 5'd0 : idx + 5'd1;
                    state_n = last ? HUNT : RECV;
                end else if (gap) begin
                    err     = 1'b1;
                    state_n = WAIT_HDR;
                end else begin
                    idx_n   = idx;
                end
            end
            default: state_n = HUNT;
        endcase
    end
    // state and frame byte index registers
    always_ff @(posedge clk) begin
        state <= reset ? HUNT : state_n;
        idx   <= reset ? 5'd0 : idx_n;
    end
    // idle counter since the last received byte, saturating at the gap length
    always_ff @(posedge clk) begin
        if (reset || uart_rx_valid)
            gap_cnt <= '0;
        else if (!gap)
            gap_cnt <= gap_cnt + GW'(1);
    end
    // registered buffer write port, frame pulses and the byte-23 flag capture
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_we    <= 1'b0;
            byte_idx   <= 5'd0;
            byte_data  <= 8'h00;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            flags      <= 8'h00;
        end else begin
            byte_we    <= wr;
            frame_done <= done;
            frame_err  <= err;
            if (wr) begin
                byte_idx  <= idx;
                byte_data <= uart_rx_data;
            end
            if (wr && idx == 5'd23)
                flags <= uart_rx_data;
        end
    end
    // watchdog: an accepted frame restarts it and loads the flags; expiry drops signal_ok and forces failsafe
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt   <= '0;
            signal_ok  <= 1'b0;
            failsafe   <= 1'b1;
            frame_lost <= 1'b0;
        end else if (done) begin
            wdog_cnt   <= '0;
            signal_ok  <= 1'b1;
            failsafe   <= flags[3];
            frame_lost <= flags[2];
        end else if (wdog_cnt >= WW'(WDOG_CYCLES - 1)) begin
            wdog_cnt   <= WW'(WDOG_CYCLES);
            signal_ok  <= 1'b0;
            failsafe   <= 1'b1;
        end else begin
            wdog_cnt   <= wdog_cnt + WW'(1);
        end
    end
`ifdef SBUS_ERR_CNT_EN
    // saturating count of aborted frames, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset)
            err_cnt <= 16'h0000;
        else if (err && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;
    end
`else
    assign err_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_sbus_frame_ctrl.sv
// tb_sbus_frame_ctrl: directed and randomized frames checked every cycle against a queue-based frame model
module tb_sbus_frame_ctrl;
    localparam int GAP  = 100;
    localparam int WDOG = 5000;
`ifdef SBUS_ERR_CNT_EN
    localparam logic [15:0] ONE_ERR = 16'd1;
`else
    localparam logic [15:0] ONE_ERR = 16'd0;
`endif
    logic        clk = 1'b0;
    logic        reset, rx_valid, rx_fe, rx_pe;
    logic [7:0]  rx_data;
    logic        byte_we, frame_done, frame_err, frame_lost, failsafe, signal_ok;
    logic [4:0]  byte_idx;
    logic [7:0]  byte_data;
    logic [15:0] err_cnt;
    int n_cmp = 0, n_bad = 0;
    int n_we = 0, n_done = 0, n_err = 0, s_we = 0, s_done = 0, s_err = 0;
    // model state
    bit         started = 0;
    int         edge_no = 0, last_quiet = 0, last_ok = 0, mode = 0;
    logic [7:0] frame[$];
    logic       e_we, e_done, e_err, e_lost, e_fs, e_ok;
    logic [4:0] e_idx;
    logic [7:0] e_data;
    logic [15:0] e_cnt;

    always #5 clk = ~clk;

    sbus_frame_ctrl #(.GAP_CYCLES(GAP), .WDOG_CYCLES(WDOG), .HDR_BYTE(8'h0F)) dut (
        .clk(clk), .reset(reset), .uart_rx_valid(rx_valid), .uart_rx_fe(rx_fe), .uart_rx_pe(rx_pe),
        .uart_rx_data(rx_data), .byte_we(byte_we), .byte_idx(byte_idx), .byte_data(byte_data),
        .frame_done(frame_done), .frame_err(frame_err), .frame_lost(frame_lost), .failsafe(failsafe),
        .signal_ok(signal_ok), .err_cnt(err_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change just after each negedge, so at the negedge they still hold what the last posedge sampled.
    always @(negedge clk) begin
        logic gap_seen, good;
        edge_no++;
        if (reset) begin
            started = 1; mode = 0; frame.delete();
            last_quiet = edge_no; last_ok = edge_no;
            e_we = 0; e_idx = 0; e_data = 0; e_done = 0; e_err = 0;
            e_lost = 0; e_fs = 1; e_ok = 0; e_cnt = 0;
        end else if (started) begin
            gap_seen = (edge_no - 1 - last_quiet) >= GAP;
            e_we = 0; e_done = 0; e_err = 0;
            if (rx_valid) begin
                last_quiet = edge_no;
                good = !rx_fe && !rx_pe;
                if (mode == 1) begin
                    if (good && rx_data == 8'h0F) begin
                        frame.delete(); frame.push_back(rx_data); mode = 2;
                        e_we = 1; e_idx = 0; e_data = rx_data;
                    end else begin
                        e_err = 1; mode = 0;
                    end
                end else if (mode == 2) begin
                    if (!good || (frame.size() == 24 && rx_data != 8'h00)) begin
                        e_err = 1; mode = 0;
                    end else begin
                        e_we = 1; e_idx = 5'(frame.size()); e_data = rx_data;
                        frame.push_back(rx_data);
                        if (frame.size() == 25) begin
                            e_done = 1; e_lost = frame[23][2]; e_fs = frame[23][3]; e_ok = 1;
                            last_ok = edge_no; mode = 0;
                        end
                    end
                end
            end else if (gap_seen) begin
                if (mode == 0) mode = 1;
                else if (mode == 2) begin e_err = 1; mode = 1; end
            end
            if (!e_done && edge_no - last_ok >= WDOG) begin e_ok = 0; e_fs = 1; end
`ifdef SBUS_ERR_CNT_EN
            if (e_err && e_cnt != 16'hFFFF) e_cnt++;
`endif
        end
        if (started) begin
            check("byte_we", byte_we, e_we);
            if (e_we) begin
                check("byte_idx", byte_idx, e_idx);
                check("byte_data", byte_data, e_data);
            end
            check("frame_done", frame_done, e_done);
            check("frame_err", frame_err, e_err);
            check("done_err_excl", frame_done & frame_err, 1'b0);
            check("frame_lost", frame_lost, e_lost);
            check("failsafe", failsafe, e_fs);
            check("signal_ok", signal_ok, e_ok);
            check("err_cnt", err_cnt, e_cnt);
            n_we += int'(byte_we); n_done += int'(frame_done); n_err += int'(frame_err);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_valid = 0; rx_fe = 0; rx_pe = 0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] d, input logic fe, input logic pe, input int sp);
        rx_valid = 1; rx_data = d; rx_fe = fe; rx_pe = pe;
        tick();
        idle(sp - 1);
    endtask

    task automatic send_frame(input logic [7:0] b23, input logic [7:0] b24, input int bad, input int sp, input bit rnd);
        logic [7:0] d;
        logic fe;
        for (int i = 0; i < 25; i++) begin
            d = (i == 0) ? 8'h0F : (i == 23) ? b23 : (i == 24) ? b24 : (rnd ? 8'($urandom) : 8'h00);
            fe = rnd && $urandom_range(0, 1) == 1;
            send(d, i == bad && fe, i == bad && !fe, sp);
        end
    endtask

    task automatic do_reset();
        reset = 1; rx_valid = 0; rx_fe = 0; rx_pe = 0;
        tick(); tick();
        reset = 0;
    endtask

    task automatic mark();
        s_we = n_we; s_done = n_done; s_err = n_err;
    endtask

    initial begin
        int kind, sp, n;
        reset = 1; rx_valid = 0; rx_fe = 0; rx_pe = 0; rx_data = 8'h00;
        do_reset();
        check("rst_failsafe", failsafe, 1'b1);
        check("rst_signal_ok", signal_ok, 1'b0);
        check("rst_byte_we", byte_we, 1'b0);
        check("rst_err_cnt", err_cnt, 16'h0000);
        // clean frame, flags 0x0C
        mark();
        idle(150);
        send_frame(8'h0C, 8'h00, -1, 20, 0);
        check("f1_we_count", n_we - s_we, 25);
        check("f1_done_count", n_done - s_done, 1);
        check("f1_frame_lost", frame_lost, 1'b1);
        check("f1_failsafe", failsafe, 1'b1);
        check("f1_signal_ok", signal_ok, 1'b1);
        // bad header then a good frame after a gap
        mark();
        idle(150);
        send(8'h55, 0, 0, 20);
        check("hdr_err_count", n_err - s_err, 1);
        check("hdr_we_count", n_we - s_we, 0);
        idle(110);
        send_frame(8'h0C, 8'h00, -1, 20, 0);
        check("hdr_done_count", n_done - s_done, 1);
        // parity error on byte 10
        do_reset();
        mark();
        idle(110);
        send_frame(8'h00, 8'h00, 10, 20, 0);
        check("pe_we_count", n_we - s_we, 10);
        check("pe_done_count", n_done - s_done, 0);
        check("pe_err_count", n_err - s_err, 1);
        check("pe_err_cnt", err_cnt, ONE_ERR);
        // truncated frame aborted by gap, next frame accepted without extra gap
        mark();
        idle(110);
        for (int i = 0; i < 6; i++) send(i == 0 ? 8'h0F : 8'h11, 0, 0, 20);
        idle(120);
        check("gap_err_count", n_err - s_err, 1);
        send_frame(8'h04, 8'h00, -1, 20, 0);
        check("gap_done_count", n_done - s_done, 1);
        // watchdog expiry and recovery
        do_reset();
        idle(110);
        send_frame(8'h00, 8'h00, -1, 20, 0);
        check("wd_ok_before", signal_ok, 1'b1);
        check("wd_fs_before", failsafe, 1'b0);
        idle(WDOG);
        check("wd_ok_expired", signal_ok, 1'b0);
        check("wd_fs_expired", failsafe, 1'b1);
        send_frame(8'h00, 8'h00, -1, 20, 0);
        check("wd_ok_recovered", signal_ok, 1'b1);
        check("wd_fs_recovered", failsafe, 1'b0);
        // reset in the middle of a frame
        mark();
        idle(110);
        for (int i = 0; i < 12; i++) send(i == 0 ? 8'h0F : 8'h22, 0, 0, 5);
        reset = 1; rx_valid = 1; rx_data = 8'h33;
        tick();
        reset = 0; rx_valid = 0;
        check("mid_rst_we", byte_we, 1'b0);
        check("mid_rst_idx", byte_idx, 5'd0);
        check("mid_rst_data", byte_data, 8'h00);
        check("mid_rst_ok", signal_ok, 1'b0);
        check("mid_rst_fs", failsafe, 1'b1);
        idle(2);
        check("mid_rst_no_err", n_err - s_err, 0);
        // randomized traffic
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 6);
            sp = $urandom_range(1, 30);
            idle($urandom_range(0, 3) == 0 ? $urandom_range(97, 103) : $urandom_range(0, 160));
            case (kind)
                0, 1, 2: send_frame(8'($urandom), 8'h00, -1, sp, 1);
                3: send_frame(8'($urandom), 8'h00, $urandom_range(0, 24), sp, 1);
                4: begin
                    n = $urandom_range(1, 5);
                    repeat (n) send(8'($urandom), $urandom_range(0, 7) == 0, 0, sp);
                end
                5: begin
                    n = $urandom_range(0, 20);
                    send(8'h0F, 0, 0, sp);
                    repeat (n) send(8'($urandom), 0, 0, sp);
                    idle($urandom_range(95, 160));
                end
                default: send_frame(8'($urandom), 8'($urandom_range(1, 255)), -1, sp, 1);
            endcase
        end
        idle(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sbus_frame_ctrl.md
SBUS_FRAME_CTRL -- requirements
Module: sbus_frame_ctrl

Interface
REQ-001 Parameter GAP_CYCLES, 50000, idle clk cycles with no uart_rx_valid that define an inter-frame gap (1 ms at 50 MHz).
REQ-002 Parameter WDOG_CYCLES, 1000000, clk cycles without frame_done before signal loss is declared (20 ms at 50 MHz).
REQ-003 Parameter HDR_BYTE, 8'h0F, required value of frame byte 0.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 uart_rx_valid  input  1  one-cycle strobe: received byte available.
REQ-007 uart_rx_fe  input  1  frame error for the current byte; qualified by uart_rx_valid.
REQ-008 uart_rx_pe  input  1  parity error (high = even-parity mismatch); qualified by uart_rx_valid.
REQ-009 uart_rx_data  input  8  received byte.
REQ-010 byte_we  output  1  one-cycle write strobe to the frame buffer.
REQ-011 byte_idx  output  5  buffer address 0..24, valid with byte_we.
REQ-012 byte_data  output  8  buffer data, valid with byte_we.
REQ-013 frame_done  output  1  one-cycle pulse: 25-byte frame accepted.
REQ-014 frame_err  output  1  one-cycle pulse: frame aborted.
REQ-015 frame_lost  output  1  byte 23 bit 2 of last accepted frame.
REQ-016 failsafe  output  1  byte 23 bit 3 of last accepted frame, forced 1 on watchdog expiry.
REQ-017 signal_ok  output  1  high while frames arrive within WDOG_CYCLES.
REQ-018 err_cnt  output  16  aborted-frame count (see Configuration).

Function
REQ-019 All outputs registered; byte_we/byte_idx/byte_data appear exactly 1 cycle after the accepting uart_rx_valid.
REQ-020 Gap counter clears on uart_rx_valid, otherwise increments, saturating at GAP_CYCLES; "gap" = counter == GAP_CYCLES.
REQ-021 States: HUNT, WAIT_HDR, RECV.
REQ-022 HUNT: bytes discarded, no byte_we; on gap -> WAIT_HDR.
REQ-023 WAIT_HDR: byte == HDR_BYTE with fe=pe=0 -> write idx 0, -> RECV with next idx 1; any other byte -> frame_err, -> HUNT.
REQ-024 RECV: error-free byte -> write at current idx, idx+1; fe or pe -> frame_err, no write, -> HUNT.
REQ-025 RECV idx 23: byte additionally captured in an internal flag register.
REQ-026 RECV idx 24: byte == 8'h00 -> write, frame_done, frame_lost/failsafe updated from flag register same cycle, -> HUNT; otherwise frame_err, no write, -> HUNT.
REQ-027 RECV with gap reached before idx 24 done -> frame_err, -> WAIT_HDR (gap already satisfied).
REQ-028 uart_rx_valid in the same cycle the gap count would be reached: byte processed in current state, gap not taken.
REQ-029 Watchdog counter clears on frame_done, saturates at WDOG_CYCLES; at WDOG_CYCLES signal_ok=0, failsafe=1; next frame_done sets signal_ok=1 and loads failsafe from the frame.
REQ-030 frame_done and frame_err never asserted in the same cycle.

Reset
REQ-031 reset overrides all inputs: state HUNT, gap, watchdog and idx counters 0, byte_we/frame_done/frame_err/frame_lost/signal_ok 0, failsafe 1, byte_idx/byte_data 0, err_cnt 0.
REQ-032 reset mid-frame discards the partial frame with no frame_err pulse.

Configuration
REQ-033 Macro SBUS_ERR_CNT_EN defined: err_cnt increments by 1 on each frame_err, saturating at 16'hFFFF, cleared only by reset.
REQ-034 SBUS_ERR_CNT_EN undefined: no counter logic, err_cnt tied to 16'h0000; port list unchanged.

Verification (GAP_CYCLES=100, WDOG_CYCLES=5000)
REQ-035 150 idle cycles, 25 clean bytes 0F, 22x00, byte23=0x0C, 00 spaced 20 cycles -> 25 byte_we idx 0..24, one frame_done, frame_lost=1, failsafe=1, signal_ok=1.
REQ-036 After gap, first byte 0x55 -> frame_err, no byte_we, HUNT; following valid frame after 100-cycle gap accepted.
REQ-037 Valid frame with uart_rx_pe=1 on idx 10 -> frame_err, 10 byte_we only, no frame_done; err_cnt=1 with macro, 0 without.
REQ-038 Header + 5 bytes, then 120 idle cycles -> frame_err at gap, next clean frame without extra gap accepted.
REQ-039 One good frame then 5000 idle cycles -> signal_ok 1->0, failsafe=1; next good frame with byte23=0x00 -> signal_ok=1, failsafe=0.
REQ-040 reset asserted at idx 12 -> no frame_err, all outputs at reset values next cycle.
